// File: rtl/full_adder.sv
// One-bit full adder with a gate-level combinational path, a registered copy of
// the result and a saturating counter of valid operations that produced a carry.
module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             in_valid,
  output logic             s,
  output logic             cout,
  output logic             s_q,
  output logic             cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat
);

  wire ab_x;
  wire sum_w;
  wire ab_and;
  wire bc_and;
  wire ac_and;
  wire carry_w;

  // Gate primitives keep X/Z propagation faithful so ripple chains behave like real gates.
  xor u_xor_ab  (ab_x, a, b);
  xor u_xor_sum (sum_w, ab_x, c);
  and u_and_ab  (ab_and, a, b);
  and u_and_bc  (bc_and, b, c);
  and u_and_ac  (ac_and, a, c);
  or  u_or_cout (carry_w, ab_and, bc_and, ac_and);

  assign s    = sum_w;
  assign cout = carry_w;

  assign cnt_sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 1'b0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q    <= sum_w;
        cout_q <= carry_w;
      end
      // Counter stops at all-ones rather than wrapping.
      if (in_valid && carry_w && !cnt_sat) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Randomised self-checking bench for full_adder: arithmetic reference model,
// an 8-bit and a 2-bit counter instance, and a four-stage unclocked ripple chain.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       c;
  logic       in_valid;

  logic       s;
  logic       cout;
  logic       s_q;
  logic       cout_q;
  logic       out_valid;
  logic [7:0] cnt;
  logic       cnt_sat;

  logic       s2;
  logic       cout2;
  logic       s_q2;
  logic       cout_q2;
  logic       out_valid2;
  logic [1:0] cnt2;
  logic       cnt_sat2;

  logic [3:0] ra;
  logic [3:0] rb;
  wire  [4:0] rc;
  wire  [3:0] rs;
  wire  [3:0] r_s_q;
  wire  [3:0] r_cout_q;
  wire  [3:0] r_valid;
  wire  [7:0] r_cnt [4];
  wire  [3:0] r_sat;

  int checks;
  int errors;

  logic m_s_q;
  logic m_cout_q;
  logic m_valid;
  int   m_cnt;
  int   m_cnt2;

  full_adder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q), .out_valid(out_valid),
    .cnt(cnt), .cnt_sat(cnt_sat)
  );

  full_adder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .s(s2), .cout(cout2), .s_q(s_q2), .cout_q(cout_q2), .out_valid(out_valid2),
    .cnt(cnt2), .cnt_sat(cnt_sat2)
  );

  assign rc[0] = 1'b0;

  // Ripple chain with the clock tied off: only the combinational path matters here.
  for (genvar i = 0; i < 4; i++) begin : g_chain
    full_adder #(.CNT_W(8)) u_stage (
      .clk(1'b0), .rst_n(1'b0), .a(ra[i]), .b(rb[i]), .c(rc[i]), .in_valid(1'b0),
      .s(rs[i]), .cout(rc[i+1]), .s_q(r_s_q[i]), .cout_q(r_cout_q[i]),
      .out_valid(r_valid[i]), .cnt(r_cnt[i]), .cnt_sat(r_sat[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_comb();
    int sum;
    sum = int'(a) + int'(b) + int'(c);
    check_output("s", 32'(s), 32'(sum % 2));
    check_output("cout", 32'(cout), 32'(sum / 2));
    check_output("sat.s", 32'(s2), 32'(sum % 2));
    check_output("sat.cout", 32'(cout2), 32'(sum / 2));
  endtask

  task automatic check_regs();
    check_output("s_q", 32'(s_q), 32'(m_s_q));
    check_output("cout_q", 32'(cout_q), 32'(m_cout_q));
    check_output("out_valid", 32'(out_valid), 32'(m_valid));
    check_output("cnt", 32'(cnt), 32'(m_cnt));
    check_output("cnt_sat", 32'(cnt_sat), 32'(m_cnt == 255));
    check_output("sat.s_q", 32'(s_q2), 32'(m_s_q));
    check_output("sat.cout_q", 32'(cout_q2), 32'(m_cout_q));
    check_output("sat.out_valid", 32'(out_valid2), 32'(m_valid));
    check_output("sat.cnt", 32'(cnt2), 32'(m_cnt2));
    check_output("sat.cnt_sat", 32'(cnt_sat2), 32'(m_cnt2 == 3));
  endtask

  task automatic clear_model();
    m_s_q    = 1'b0;
    m_cout_q = 1'b0;
    m_valid  = 1'b0;
    m_cnt    = 0;
    m_cnt2   = 0;
  endtask

  // Drive one operation on a falling edge, then model and check the rising edge.
  task automatic apply_stimulus(input logic va, input logic vb, input logic vc,
                                input logic vv, input logic vr);
    int sum;
    @(negedge clk);
    a        = va;
    b        = vb;
    c        = vc;
    in_valid = vv;
    rst_n    = vr;
    #1;
    check_comb();
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        sum      = int'(a) + int'(b) + int'(c);
        m_s_q    = (sum % 2) == 1;
        m_cout_q = sum >= 2;
        if (sum >= 2) begin
          m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
      end
    end
    #1;
    check_regs();
  endtask

  // Assert reset between edges and confirm it acts without a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_regs();
    a = 1'b1;
    b = 1'b0;
    c = 1'b1;
    #1;
    check_comb();
  endtask

  task automatic check_chain();
    #1;
    check_output("chain.sum", 32'({rc[4], rs}), 32'(int'(ra) + int'(rb)));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    c        = 1'b0;
    in_valid = 1'b0;
    ra       = 4'd0;
    rb       = 4'd0;
    clear_model();

    #2;
    check_regs();

    // All eight input combinations, with reset held so only the gates are active.
    for (int i = 0; i < 8; i++) begin
      a = i[2];
      b = i[1];
      c = i[0];
      #1;
      check_output("exh.sum", 32'({cout, s}), 32'(int'(a) + int'(b) + int'(c)));
      check_regs();
    end

    // Release with a capture on the very first edge, then saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check_output("sat.seq", 32'(cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
      check_output("sat.flag", 32'(cnt_sat2), 32'(k >= 2));
    end

    async_reset();
    check_output("ar.cnt2", 32'(cnt2), 32'd0);
    check_output("ar.valid", 32'(out_valid), 32'd0);

    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_output("reg.s_q", 32'(s_q), 32'd0);
    check_output("reg.cout_q", 32'(cout_q), 32'd1);
    check_output("reg.valid", 32'(out_valid), 32'd1);
    check_output("reg.cnt", 32'(cnt), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("idle.valid", 32'(out_valid), 32'd0);
    check_output("idle.cout_q", 32'(cout_q), 32'd1);

    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check_output("nocarry.cnt", 32'(cnt), 32'd1);
      check_output("nocarry.s_q", 32'(s_q), 32'd1);
    end

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 31) != 0));
    end

    async_reset();
    for (int i = 0; i < 260; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    check_output("main.sat", 32'(cnt), 32'd255);
    check_output("main.sat_flag", 32'(cnt_sat), 32'd1);

    ra = 4'b1011;
    rb = 4'b1010;
    #1;
    check_output("chain.s", 32'(rs), 32'b0101);
    check_output("chain.carry", 32'(rc[4:1]), 32'b1010);
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      check_chain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event counter; legal range 1..32.
REQ-002 Port clk, input, 1: single clock; all registered logic updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port a, input, 1: addend bit.
REQ-005 Port b, input, 1: addend bit.
REQ-006 Port c, input, 1: carry-in bit.
REQ-007 Port in_valid, input, 1: qualifies a/b/c for the registered path and the counter.
REQ-008 Port s, output, 1: combinational sum bit.
REQ-009 Port cout, output, 1: combinational carry-out bit.
REQ-010 Port s_q, output, 1: registered sum.
REQ-011 Port cout_q, output, 1: registered carry-out.
REQ-012 Port out_valid, output, 1: s_q/cout_q hold a valid result.
REQ-013 Port cnt, output, CNT_W: saturating count of valid operations with carry-out = 1.
REQ-014 Port cnt_sat, output, 1: high while cnt equals all-ones.

Function
REQ-015 s SHALL equal a XOR b XOR c, built from gate primitives.
REQ-016 cout SHALL equal (a AND b) OR (b AND c) OR (a AND c), built from gate primitives.
REQ-017 s and cout SHALL be purely combinational, with zero cycle latency, independent of clk, rst_n and in_valid; this supports ripple chaining with clk unconnected.
REQ-018 On a rising edge with in_valid = 1, s_q and cout_q SHALL load s and cout, and out_valid SHALL be set to 1 (latency 1 cycle).
REQ-019 On a rising edge with in_valid = 0, s_q and cout_q SHALL hold their values, and out_valid SHALL be set to 0.
REQ-020 On a rising edge with in_valid = 1 and cout = 1, cnt SHALL increment by 1 unless it is all-ones.
REQ-021 At all-ones, cnt SHALL hold; there is no wrap-around.
REQ-022 cnt SHALL be unchanged when in_valid = 0 or cout = 0.
REQ-023 cnt_sat SHALL be a combinational decode of cnt equal to 2^CNT_W-1.
REQ-024 X or Z on a, b or c SHALL NOT be masked; it propagates per gate semantics.

Reset
REQ-025 While rst_n = 0, s_q, cout_q and out_valid SHALL be 0, cnt SHALL be 0, and cnt_sat SHALL be 0, regardless of clk.
REQ-026 Reset assertion mid-operation SHALL clear the registered state immediately, without waiting for a clock edge; s and cout SHALL be unaffected.
REQ-027 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; an in_valid pulse on that edge SHALL be captured.

Verification
REQ-028 Exhaustive combinational check: all 8 combinations of a/b/c -> {cout,s} = a+b+c, e.g. 1,1,1 -> cout=1, s=1; 1,0,0 -> cout=0, s=1.
REQ-029 Four-instance ripple chain with LSB carry-in 0, a=1011, b=1010, clk unconnected -> s=0101, carries c[3:0]=1010.
REQ-030 Registered path: rst_n released, then a=1, b=1, c=0 with in_valid=1 for one edge -> next cycle s_q=0, cout_q=1, out_valid=1, cnt=1; the following idle cycle -> out_valid=0, s_q/cout_q held.
REQ-031 Saturation: CNT_W=2, apply a=b=1 with in_valid=1 for 5 edges -> cnt goes 1, 2, 3, 3, 3; cnt_sat=1 from the third edge on.
REQ-032 Asynchronous reset: assert rst_n=0 between clock edges while cnt=3 and out_valid=1 -> cnt=0, out_valid=0, s_q=0, cout_q=0 immediately; s/cout still track a/b/c.
REQ-033 No count without carry: in_valid=1 with a=1, b=0, c=0 for 3 edges -> cnt unchanged, s_q=1, cout_q=0.
